// File: rtl/sram_spi_channel.sv
// sram_spi_channel
//   Serial SRAM responder for a single 23LC1024-class SPI SRAM. It takes one
//   command from the task manager (inst/address/byte_length) and runs it on
//   the SPI pins in mode 0. Data moves bit-serially, MSB first, in both
//   directions. Supported opcodes: 0x03 READ, 0x02 WRITE, 0x05 RDMR,
//   0x01 WRMR. Any other nonzero opcode completes with rw_done and produces
//   no SPI activity.
//
// Parameters
//   CLK_DIV      clk cycles per SCK half-period (1..255)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   inst         SPI opcode, 0 = no task
//   address      24-bit byte address (READ/WRITE only)
//   byte_length  number of data bytes
//   write_in     write data bit, consumed while io_valid=1 on writes
//   mem_out      read data bit, valid while io_valid=1 on reads
//   io_valid     one-cycle pulse per data bit
//   rw_done      one-cycle pulse at the end of a transaction
//   busy         high while a supported transaction is in progress
//   sram_cs_n    SPI chip select (active low)
//   sram_sck     SPI clock, idles low
//   sram_mosi    SPI data to the SRAM
//   sram_miso    SPI data from the SRAM
//
// Build option
//   SRAM_SPI_ABORT_EN  when defined, inst dropping to 0 during the shift
//                      phase ends the transfer after the current bit.
module sram_spi_channel #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  inst,
    input  logic [23:0] address,
    input  logic [23:0] byte_length,
    input  logic        write_in,
    output logic        mem_out,
    output logic        io_valid,
    output logic        rw_done,
    output logic        busy,
    output logic        sram_cs_n,
    output logic        sram_sck,
    output logic        sram_mosi,
    input  logic        sram_miso
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SHIFT,
        S_FINISH,
        S_DONE,
        S_REARM
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  op_q;
    logic [31:0] hdr_q;      // opcode (+ address), left-aligned
    logic [27:0] rem_q;      // bits remaining, including the current one
    logic [27:0] dbits_q;    // data-phase bits (8 * byte_length)
    logic [7:0]  div_q;
    logic        sck_q;
    logic        mosi_q;
    logic        cs_n_q;
    logic        busy_q;
    logic        mem_out_q;
    logic        rd_valid_q;

    logic op_is_rd, op_is_wr, op_ok, inst_addr;
    logic div_end, bit_end, last_bit, stop_req, advance;
    logic cur_is_data, next_is_data, wr_take;

    assign op_is_rd  = (op_q == 8'h03) || (op_q == 8'h05);
    assign op_is_wr  = (op_q == 8'h02) || (op_q == 8'h01);
    assign op_ok     = op_is_rd || op_is_wr;
    assign inst_addr = (inst == 8'h02) || (inst == 8'h03);

    assign div_end      = (div_q == DIV_LAST);
    assign bit_end      = sck_q && div_end;          // SCK falling edge due
    assign last_bit     = (rem_q == 28'd1);
    // Data bits are always the tail of the frame, so position alone tells
    // whether the current / next bit belongs to the data phase.
    assign cur_is_data  = (rem_q <= dbits_q);
    assign next_is_data = ((rem_q - 28'd1) <= dbits_q);

`ifdef SRAM_SPI_ABORT_EN
    logic abort_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort_q <= 1'b0;
        end else if (state_q == S_START) begin
            abort_q <= 1'b0;
        end else if (state_q == S_SHIFT && inst == '0) begin
            abort_q <= 1'b1;
        end
    end

    assign stop_req = abort_q || (inst == '0);
`else
    assign stop_req = 1'b0;
`endif

    assign advance = bit_end && !last_bit && !stop_req;
    // write_in is taken in the cycle before the falling edge that loads it
    assign wr_take = (state_q == S_SHIFT) && advance && op_is_wr && next_is_data;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (inst != '0) state_d = S_START;
            S_START:  state_d = op_ok ? S_SHIFT : S_DONE;
            S_SHIFT:  if (bit_end && (last_bit || stop_req)) state_d = S_FINISH;
            S_FINISH: if (cs_n_q) state_d = S_DONE;
            S_DONE:   state_d = S_REARM;
            S_REARM:  if (div_end && inst == '0) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        rw_done  = (state_q == S_DONE);
        io_valid = rd_valid_q || wr_take;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            hdr_q      <= '0;
            rem_q      <= '0;
            dbits_q    <= '0;
            div_q      <= '0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            mem_out_q  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (inst != '0) begin
                        op_q    <= inst;
                        hdr_q   <= inst_addr ? {inst, address} : {inst, 24'h0};
                        dbits_q <= {1'b0, byte_length, 3'b000};
                        rem_q   <= (inst_addr ? 28'd32 : 28'd8) + {1'b0, byte_length, 3'b000};
                    end
                end
                S_START: begin
                    div_q <= '0;
                    if (op_ok) begin
                        cs_n_q <= 1'b0;
                        busy_q <= 1'b1;
                        mosi_q <= hdr_q[31];
                        hdr_q  <= {hdr_q[30:0], 1'b0};
                    end
                end
                S_SHIFT: begin
                    if (div_end) begin
                        div_q <= '0;
                        sck_q <= ~sck_q;
                        if (!sck_q) begin
                            if (op_is_rd && cur_is_data) begin
                                mem_out_q  <= sram_miso;
                                rd_valid_q <= 1'b1;
                            end
                        end else if (advance) begin
                            rem_q <= rem_q - 28'd1;
                            if (next_is_data) begin
                                mosi_q <= op_is_wr ? write_in : 1'b0;
                            end else begin
                                mosi_q <= hdr_q[31];
                                hdr_q  <= {hdr_q[30:0], 1'b0};
                            end
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                S_FINISH: begin
                    // CS stays low for CLK_DIV cycles, then one cycle high
                    // before DONE so rw_done trails the CS rise by a cycle.
                    if (!cs_n_q) begin
                        if (div_end) begin
                            cs_n_q <= 1'b1;
                            mosi_q <= 1'b0;
                            div_q  <= '0;
                        end else begin
                            div_q <= div_q + 8'd1;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_DONE: begin
                    div_q <= '0;
                end
                S_REARM: begin
                    if (!div_end) div_q <= div_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign mem_out   = mem_out_q;
    assign busy      = busy_q;
    assign sram_cs_n = cs_n_q;
    assign sram_sck  = sck_q;
    assign sram_mosi = mosi_q;

endmodule

// File: tb/tb_sram_spi_channel.sv
`timescale 1ns/1ps
module tb_sram_spi_channel;
    localparam int unsigned DIV = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  inst = '0;
    logic [23:0] address = '0;
    logic [23:0] byte_length = '0;
    logic        write_in = 1'b0;
    logic        sram_miso = 1'b0;
    logic        mem_out, io_valid, rw_done, busy, sram_cs_n, sram_sck, sram_mosi;

    sram_spi_channel #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .address(address),
        .byte_length(byte_length), .write_in(write_in), .mem_out(mem_out),
        .io_valid(io_valid), .rw_done(rw_done), .busy(busy),
        .sram_cs_n(sram_cs_n), .sram_sck(sram_sck), .sram_mosi(sram_mosi),
        .sram_miso(sram_miso)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // ---------------- reference model of the current command ----------------
    logic [7:0]  m_op;
    logic [31:0] m_hdr;
    int          m_hdr_bits;
    int          m_len;
    bit          m_wr, m_rd, m_supp;
    int          m_abort;
    logic [7:0]  m_dat [8];   // write payload, and SRAM contents for reads

    function automatic logic data_bit(input int j);
        logic [7:0] b;
        if (j < 0 || j >= 8 * m_len) return 1'b0;
        b = m_dat[j / 8];
        return b[7 - (j % 8)];
    endfunction

    // Frame bit n on the wire: opcode/address header, then payload.
    function automatic logic model_bit(input int n);
        if (n < m_hdr_bits) return m_hdr[31 - n];
        return data_bit(n - m_hdr_bits);
    endfunction

    function automatic int exp_bits();
        if (!m_supp) return 0;
`ifdef SRAM_SPI_ABORT_EN
        if (m_abort > 0) return m_abort;
`endif
        return m_hdr_bits + 8 * m_len;
    endfunction

    function automatic int exp_valids();
        if (!m_supp) return 0;
        return (exp_bits() > m_hdr_bits) ? exp_bits() - m_hdr_bits : 0;
    endfunction

    // ---------------- monitor / compare process ----------------
    int          txn_id = 0, seen_id = 0;
    bit          active = 0;
    int          cyc, rises, vcount, last_rise, last_v, cs_rise, done_cnt;
    bit          cs_fell;
    logic        prev_sck = 1'b0, prev_cs = 1'b1;
    logic [63:0] mosi_sr, rd_sr;

    always @(negedge clk) begin
        if (!rst_n) begin
            active   = 0;
            prev_sck = 1'b0;
            prev_cs  = 1'b1;
        end else begin
            if (txn_id != seen_id) begin
                seen_id = txn_id; active = 1; cyc = 0; rises = 0; vcount = 0;
                last_rise = 0; last_v = 0; cs_rise = -100; done_cnt = 0;
                cs_fell = 0; mosi_sr = '0; rd_sr = '0;
            end else begin
                cyc++;
            end
            if (active) begin
                if (!sram_cs_n) begin
                    cs_fell = 1;
                    chk("busy_while_cs", busy, 1);
                end
                if (!prev_sck && sram_sck) begin
                    chk("rise_cs_low", sram_cs_n, 0);
                    if (rises == 0) chk("first_rise_cyc", cyc, 2 + DIV);
                    else            chk("rise_spacing", cyc - last_rise, 2 * DIV);
                    last_rise = cyc;
                    mosi_sr = {mosi_sr[62:0], sram_mosi};
                    if (rises < m_hdr_bits || m_wr) chk("mosi_bit", sram_mosi, model_bit(rises));
                    rises++;
                end
                if (io_valid) begin
                    if (vcount > 0) chk("valid_spacing", cyc - last_v, 2 * DIV);
                    last_v = cyc;
                    if (m_rd) begin
                        chk("rd_valid_after_rise", {prev_sck, sram_sck}, 2'b01);
                        chk("rd_valid_pos", rises, m_hdr_bits + vcount + 1);
                        chk("mem_out", mem_out, data_bit(vcount));
                    end else begin
                        chk("wr_valid_sck_high", sram_sck, 1);
                        chk("wr_valid_pos", rises, m_hdr_bits + vcount);
                    end
                    rd_sr = {rd_sr[62:0], mem_out};
                    vcount++;
                end
                if (!prev_cs && sram_cs_n) begin
                    cs_rise = cyc;
                    chk("cs_rise_sck_low", sram_sck, 0);
                end
                if (rw_done) begin
                    done_cnt++;
                    chk("done_once", done_cnt, 1);
                    if (m_supp) begin
                        chk("done_after_cs", cyc, cs_rise + 1);
                    end else begin
                        chk("badop_done_cyc", cyc, 2);
                        chk("badop_no_cs", cs_fell, 0);
                    end
                    chk("bits_total", rises, exp_bits());
                    chk("valid_total", vcount, exp_valids());
                    chk("busy_at_done", busy, 0);
                    active = 0;
                end
            end else if (!sram_cs_n || rw_done || sram_sck || io_valid) begin
                chk("quiet_between_txns", {sram_cs_n, rw_done, sram_sck, io_valid}, 4'b1000);
            end
            prev_sck = sram_sck;
            prev_cs  = sram_cs_n;
        end
    end

    // SRAM model: shifts out the next frame bit after each SCK falling edge.
    initial forever begin
        @(negedge sram_sck or negedge sram_cs_n);
        sram_miso = model_bit(rises);
    end

    // Write data feeder: always presents the next payload bit.
    initial forever begin
        @(posedge clk); #1;
        write_in = data_bit(vcount);
    end

    // ---------------- driver ----------------
    task automatic set_model(input logic [7:0] op, input logic [23:0] a, input int len, input int abort_at);
        bit addr;
        m_op       = op;
        m_supp     = (op == 8'h01) || (op == 8'h02) || (op == 8'h03) || (op == 8'h05);
        m_wr       = (op == 8'h01) || (op == 8'h02);
        m_rd       = (op == 8'h03) || (op == 8'h05);
        addr       = (op == 8'h02) || (op == 8'h03);
        m_hdr_bits = addr ? 32 : 8;
        m_hdr      = addr ? {op, a} : {op, 24'h0};
        m_len      = len;
        m_abort    = abort_at;
    endtask

    task automatic issue(input logic [7:0] op, input logic [23:0] a, input int len);
        @(posedge clk); #1;
        inst        = op;
        address     = a;
        byte_length = 24'(len);
        txn_id++;
    endtask

    task automatic run_txn(input logic [7:0] op, input logic [23:0] a, input int len,
                           input int abort_at, input bit hold);
        bit got;
        int lows;
        set_model(op, a, len, abort_at);
        issue(op, a, len);
        got = 0;
        for (int i = 0; i < 5000 && !got; i++) begin
            @(posedge clk); #1;
            if (abort_at > 0 && rises >= abort_at) inst = '0;
            if (done_cnt > 0) got = 1;
        end
        chk("txn_timeout", got, 1);
        if (hold) begin
            lows = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (!sram_cs_n || busy) lows++;
            end
            chk("held_inst_no_retrigger", lows, 0);
        end
        inst = '0;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] op;
        int         k;
        bit         got;

        repeat (3) @(negedge clk);
        chk("rst_cs_n", sram_cs_n, 1);
        chk("rst_sck", sram_sck, 0);
        chk("rst_mosi", sram_mosi, 0);
        chk("rst_mem_out", mem_out, 0);
        chk("rst_io_valid", io_valid, 0);
        chk("rst_rw_done", rw_done, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // WRITE 0x02 @0x000010, 0xA55A
        m_dat[0] = 8'hA5; m_dat[1] = 8'h5A;
        run_txn(8'h02, 24'h000010, 2, 0, 0);
        chk("tp_write_stream", mosi_sr[47:0], 48'h02_000010_A55A);
        chk("tp_write_bits", rises, 48);
        chk("tp_write_valids", vcount, 16);

        // READ 0x03 @0x01FFFF, SRAM returns 0xC3
        m_dat[0] = 8'hC3;
        run_txn(8'h03, 24'h01FFFF, 1, 0, 0);
        chk("tp_read_data", rd_sr[7:0], 8'hC3);
        chk("tp_read_valids", vcount, 8);
        chk("tp_read_hdr", mosi_sr[39:8], 32'h03_01FFFF);

        // READ with byte_length=0, inst held afterwards
        run_txn(8'h03, 24'h000123, 0, 0, 1);
        chk("tp_len0_bits", rises, 32);
        chk("tp_len0_valids", vcount, 0);

        // Unsupported opcode
        run_txn(8'h7F, 24'h0, 1, 0, 0);
        chk("tp_badop_bits", rises, 0);

        // Reset in the middle of a 4-byte write
        for (int i = 0; i < 4; i++) m_dat[i] = 8'($urandom);
        set_model(8'h02, 24'h000400, 4, 0);
        issue(8'h02, 24'h000400, 4);
        got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(posedge clk); #1;
            if (rises >= 45) got = 1;
        end
        chk("rst_reach_data", got, 1);
        rst_n = 1'b0;
        inst  = '0;
        #1;
        chk("midrst_cs_n", sram_cs_n, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_sck", sram_sck, 0);
        chk("midrst_rw_done", rw_done, 0);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_done", rw_done, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_quiet", {sram_cs_n, rw_done, busy}, 3'b100);
        end
        m_dat[0] = 8'h3C; m_dat[1] = 8'h81;
        run_txn(8'h02, 24'h000020, 2, 0, 0);
        chk("post_rst_write", mosi_sr[47:0], 48'h02_000020_3C81);

        // inst dropped after 40 bits of a 4-byte read
        for (int i = 0; i < 4; i++) m_dat[i] = 8'($urandom);
        run_txn(8'h03, 24'h000800, 4, 40, 0);
`ifdef SRAM_SPI_ABORT_EN
        chk("abort_bits", rises, 40);
`else
        chk("abort_bits", rises, 64);
`endif

        // Randomized commands
        for (int n = 0; n < 12; n++) begin
            k = $urandom_range(0, 4);
            case (k)
                0:       op = 8'h02;
                1:       op = 8'h03;
                2:       op = 8'h05;
                3:       op = 8'h01;
                default: op = 8'($urandom_range(6, 255));
            endcase
            for (int i = 0; i < 8; i++) m_dat[i] = 8'($urandom);
            run_txn(op, 24'($urandom_range(0, 17'h1FFFF)), $urandom_range(0, 3), 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
